// File: rtl/axi_arb_pkg.sv
// Shared types for the weighted round-robin stream arbiter.
package axi_arb_pkg;

  localparam int DATA_SIZE = 32;
  localparam int ID_SIZE   = 8;

  typedef logic [DATA_SIZE-1:0] TData;
  typedef logic [ID_SIZE-1:0]   TId;

  // Flattened copy of one stream's forward signals. Interface array elements
  // cannot be selected with a run-time index, so the arbiter copies them here.
  typedef struct packed {
    logic t_valid;
    logic t_last;
    TData t_data;
    TId   t_id;
  } axi_stream_t;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle: handshake, packet delimiter, data and id.
interface IAxiStream;
  logic               t_valid;
  logic               t_ready;
  logic               t_last;
  axi_arb_pkg::TData  t_data;
  axi_arb_pkg::TId    t_id;

  modport Master (output t_valid, t_last, t_data, t_id, input t_ready);
  modport Slave  (input t_valid, t_last, t_data, t_id, output t_ready);
endinterface

// File: rtl/axi_rr_pick.sv
// Round-robin pointer advance: first requester strictly after cur_idx,
// wrapping, with cur_idx itself considered last. Holds cur_idx if nobody asks.
module axi_rr_pick #(
  parameter int NUM_CHANNELS = 4,
  parameter int CHANNELS_W   = $clog2(NUM_CHANNELS)
) (
  input  logic [CHANNELS_W-1:0]   cur_idx,
  input  logic [NUM_CHANNELS-1:0] requests,
  output logic [CHANNELS_W-1:0]   next_idx
);

  logic [CHANNELS_W-1:0] cand;
  logic                  found;

  // Scan offsets 1..NUM_CHANNELS; the index width makes the addition wrap.
  always_comb begin
    next_idx = cur_idx;
    cand     = cur_idx;
    found    = 1'b0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = cur_idx + CHANNELS_W'(i);
      if (!found && requests[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wrr_arbiter.sv
// Weighted round-robin packet arbiter merging NUM_CHANNELS streams onto one.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | between packets; grant decision is registered here
// TRANSFER | forwarding the granted channel until its last beat handshakes
module axi_wrr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CHANNELS_W   = $clog2(NUM_CHANNELS),
  parameter int WEIGHT_W     = 4,
  parameter int STALL_W      = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_n,
  IAxiStream.Slave                         in [NUM_CHANNELS],
  IAxiStream.Master                        out,
  input  logic [NUM_CHANNELS*WEIGHT_W-1:0] weight_i,
  output logic [CHANNELS_W-1:0]            grant_idx_o,
  output logic                             busy_o,
  output logic                             stall_err_o,
  input  logic                             stall_clr_i
);

  arb_state_e            state_q, state_d;
  logic [CHANNELS_W-1:0] grant_q, grant_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                  stall_err_q, stall_err_d;

  axi_stream_t             in_s [NUM_CHANNELS];
  axi_stream_t             sel;
  logic [NUM_CHANNELS-1:0] requests;
  logic [NUM_CHANNELS-1:0] ready_vec;
  logic [CHANNELS_W-1:0]   next_idx;
  logic [WEIGHT_W-1:0]     new_weight;
  logic                    busy;
  logic                    out_valid;
  logic                    out_last;
  logic                    last_hs;
  logic                    stall_inc;
  logic                    stall_set;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_in
    assign in_s[k] = '{t_valid: in[k].t_valid,
                       t_last:  in[k].t_last,
                       t_data:  in[k].t_data,
                       t_id:    in[k].t_id};
    assign requests[k]  = in[k].t_valid;
    assign in[k].t_ready = ready_vec[k];
  end

  axi_rr_pick #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CHANNELS_W   (CHANNELS_W)
  ) u_pick (
    .cur_idx  (grant_q),
    .requests (requests),
    .next_idx (next_idx)
  );

  assign sel       = in_s[grant_q];
  assign busy      = (state_q == TRANSFER);
  assign out_valid = busy & sel.t_valid;
  assign out_last  = busy & sel.t_last;
  assign last_hs   = out_valid & out.t_ready & out_last;

  assign out.t_valid = out_valid;
  assign out.t_last  = out_last;
  assign out.t_data  = sel.t_data;
  assign out.t_id    = sel.t_id;

  assign grant_idx_o = grant_q;
  assign busy_o      = busy;
  assign stall_err_o = stall_err_q;

  // Only the granted channel sees ready, and only while a packet is open.
  always_comb begin
    ready_vec          = '0;
    ready_vec[grant_q] = busy & out.t_ready;
  end

  // Next state and grant/credit bookkeeping. The weight is read only when
  // credit reloads, so mid-burst weight changes wait for the next rotation.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    credit_d   = credit_q;
    new_weight = weight_i[int'(next_idx)*WEIGHT_W +: WEIGHT_W];
    unique case (state_q)
      IDLE: begin
        if (|requests) begin
          state_d = TRANSFER;
          if (!((credit_q != '0) && requests[grant_q])) begin
            grant_d  = next_idx;
            credit_d = (new_weight == '0) ? WEIGHT_W'(1) : new_weight;
          end
        end
      end
      TRANSFER: begin
        if (last_hs) begin
          state_d = IDLE;
          if (credit_q != '0) credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog: counts cycles the open packet's source withholds valid. The flag
  // sets on the step into all-ones, so a clear while still saturated sticks.
  always_comb begin
    stall_inc   = busy & ~sel.t_valid;
    stall_set   = 1'b0;
    stall_cnt_d = '0;
    if (stall_inc) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_W'(1);
      else                   stall_cnt_d = stall_cnt_q;
      stall_set = (stall_cnt_q == {{(STALL_W-1){1'b1}}, 1'b0});
    end
    if (stall_set)        stall_err_d = 1'b1;
    else if (stall_clr_i) stall_err_d = 1'b0;
    else                  stall_err_d = stall_err_q;
  end

  // State registers; grant resets to the top index so channel 0 wins first.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '1;
      credit_q    <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      credit_q    <= credit_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

endmodule

// File: doc/axi_wrr_arbiter.md
Name: axi_wrr_arbiter

Overview:
- Weighted round-robin packet arbiter: merges NUM_CHANNELS AXI-Stream masters onto one AXI-Stream output.
- Each grant lets a channel send up to weight_i[ch] whole packets back-to-back before the grant rotates.
- Packets are never interleaved.
- Sits in front of a shared downstream stream consumer. Also provides a stall watchdog and grant visibility for debug/status registers.

Parameters:
- NUM_CHANNELS, 4, number of input channels (power of two, >=2).
- CHANNELS_W, $clog2(NUM_CHANNELS), grant index width.
- WEIGHT_W, 4, per-channel weight field width.
- STALL_W, 8, stall watchdog counter width.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in  IAxiStream.Slave  [NUM_CHANNELS]  input streams (t_valid/t_ready/t_last, t_data 32b, t_id 8b).
- out  IAxiStream.Master  1  merged output stream.
- weight_i  input  NUM_CHANNELS*WEIGHT_W  packets-per-grant; channel k occupies bits [k*WEIGHT_W +: WEIGHT_W].
- grant_idx_o  output  CHANNELS_W  currently granted channel.
- busy_o  output  1  high in TRANSFER state.
- stall_err_o  output  1  sticky watchdog flag.
- stall_clr_i  input  1  clears stall_err_o.

Behaviour:
- Reset values: state=IDLE, grant_idx='1 (so channel 0 wins the first arbitration), credit=0, stall counter=0, stall_err_o=0. Consequently out.t_valid=0, out.t_last=0, all in[k].t_ready=0, busy_o=0.
- States: IDLE and TRANSFER.
- IDLE -> TRANSFER when |requests, where requests[k]=in[k].t_valid.
- TRANSFER -> IDLE on output handshake of the last beat: out.t_valid & out.t_ready & out.t_last.
- Grant decision, registered in IDLE when |requests:
  - Keep: if credit!=0 and requests[grant_idx], grant_idx and credit are unchanged.
  - Rotate: otherwise grant_idx = first requester scanning from grant_idx+1 upward, modulo NUM_CHANNELS. credit loads weight of the new channel, with weight 0 treated as 1. Unused credit of the old channel is forfeited.
- Credit decrements by 1, saturating at 0, on each last-beat handshake.
- Weights are sampled only when credit loads. Changes mid-burst take effect at the next rotation.
- Latency: first beat appears on out one cycle after the request is seen in IDLE. There is one IDLE bubble between packets, including within a burst.
- Datapath: combinational mux by grant_idx.
  - out.t_valid and out.t_last = selected channel's signal when in TRANSFER, else 0.
  - out.t_data and out.t_id = selected channel's fields, ungated.
- in[k].t_ready = (k==grant_idx) & TRANSFER & out.t_ready. Non-granted channels see t_ready=0.
- The granted channel may drop t_valid mid-packet; the arbiter waits and holds the grant.
- Stall watchdog:
  - Counter clears when not in TRANSFER or when the selected t_valid=1.
  - Otherwise it increments, saturating at all-ones.
  - Reaching all-ones sets stall_err_o.
  - stall_clr_i clears stall_err_o. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is abandoned with no further beats forwarded.
- grant_idx_o = grant_idx register. busy_o = (state==TRANSFER).

Decomposition:
- Package axi_arb_pkg: DATA_SIZE=32, ID_SIZE=8, TData/TId typedefs, axi_stream_t struct (adapter for variable-index access to the interface array), state enum.
- Sub-module axi_rr_pick: combinational; inputs cur_idx and requests, output next_idx. Reusable by other arbiters.

Test Plan:
- Reset check: hold rst_n=0 with all inputs valid -> out.t_valid=0, all in[k].t_ready=0, grant_idx_o=3. Release -> channel 0 first beat on out at cycle 2.
- Weighted rotation: weights {ch0=2,1,1,1}, all channels continuously send 1-beat packets, out.t_ready=1 -> packet source order 0,0,1,2,3,0,0,1...
- Zero weight and forfeit: weight ch1=0 -> treated as 1. Channel 0 with weight 3 drops valid after its first packet -> grant moves to channel 1 immediately.
- Multi-beat and backpressure: ch2 sends a 4-beat packet while out.t_ready toggles 1,0,0,1... and other channels request -> no beat from another channel until ch2 t_last handshakes. Data stable while t_ready=0.
- Watchdog: granted ch1 deasserts t_valid mid-packet for 255 cycles -> stall_err_o=1. Pulse stall_clr_i concurrently with the set condition -> flag stays 1. Later clear -> 0.
- Reset mid-packet: assert rst_n=0 during beat 2 of 4 -> outputs return to reset values asynchronously, before the next clock edge.
